// File: rtl/kogge_stone_adder.sv
// rtl/kogge_stone_adder.sv - registered WIDTH-bit Kogge-Stone prefix adder
// Carry-in is folded into the bit-0 generate so the tree needs no extra level.
module kogge_stone_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
);
    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_g_final;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_p0 = A ^ B;

    genvar k;
    generate
        for (k = 0; k <= LEVELS; k++) begin : g_lvl
            logic [WIDTH-1:0] w_g;
            logic [WIDTH-1:0] w_p;
            if (k == 0) begin : g_init
                assign w_g = (A & B) | {{(WIDTH-1){1'b0}}, w_p0[0] & Cin};
                assign w_p = w_p0;
            end else begin : g_tree
                localparam int D = 1 << (k - 1);
                // Bits below the span pass through; the rest are black cells.
                assign w_g[D-1:0] = g_lvl[k-1].w_g[D-1:0];
                assign w_p[D-1:0] = g_lvl[k-1].w_p[D-1:0];
                assign w_g[WIDTH-1:D] = g_lvl[k-1].w_g[WIDTH-1:D]
                                      | (g_lvl[k-1].w_p[WIDTH-1:D] & g_lvl[k-1].w_g[WIDTH-1-D:0]);
                assign w_p[WIDTH-1:D] = g_lvl[k-1].w_p[WIDTH-1:D] & g_lvl[k-1].w_p[WIDTH-1-D:0];
            end
        end
    endgenerate

    assign w_g_final = g_lvl[LEVELS].w_g;
    assign w_carry   = {w_g_final[WIDTH-2:0], Cin};
    assign w_sum     = w_p0 ^ w_carry;
    assign w_cout    = w_g_final[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign Sum       = r_sum;
    assign Cout      = r_cout;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_kogge_stone_adder.sv
// tb/tb_kogge_stone_adder.sv - checks 8/16/32-bit Kogge-Stone adders against integer arithmetic
module tb_kogge_stone_adder;
    logic clk = 1'b0;
    logic rst_n;

    logic [7:0]  a8,  b8,  sum8;
    logic [15:0] a16, b16, sum16;
    logic [31:0] a32, b32, sum32;
    logic cin8, cin16, cin32, v8, v16, v32;
    logic cout8, cout16, cout32, ov8, ov16, ov32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    kogge_stone_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(v8),
        .Sum(sum8), .Cout(cout8), .out_valid(ov8)
    );
    kogge_stone_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .in_valid(v16),
        .Sum(sum16), .Cout(cout16), .out_valid(ov16)
    );
    kogge_stone_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .Cin(cin32), .in_valid(v32),
        .Sum(sum32), .Cout(cout32), .out_valid(ov32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        a8 = a; b8 = b; cin8 = c; v8 = 1'b1;
        tick();
        check({tag, "_sum"},   sum8,  exp_sum);
        check({tag, "_cout"},  cout8, exp_cout);
        check({tag, "_valid"}, ov8,   1'b1);
    endtask

    initial begin
        logic [63:0] e8, e16, e32;

        rst_n = 1'b0;
        a8 = '0; b8 = '0; cin8 = 0; v8 = 0;
        a16 = '0; b16 = '0; cin16 = 0; v16 = 0;
        a32 = '0; b32 = '0; cin32 = 0; v32 = 0;
        #2;
        check("rst_sum",   sum8,  0);
        check("rst_cout",  cout8, 0);
        check("rst_valid", ov8,   0);
        check("rst_valid32", ov32, 0);
        #10 rst_n = 1'b1;

        run8("zero",     8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run8("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        run8("ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        run8("55_aa_c1", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1);
        run8("max_c0",   8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
        run8("max_c1",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Inputs wander (including X) while idle; the last result must persist.
        v8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a8 = (i == 0) ? 8'hxx : 8'($urandom);
            b8 = 8'($urandom);
            cin8 = (i == 1) ? 1'bx : 1'($urandom);
            tick();
            check("hold_sum",   sum8,  8'hFF);
            check("hold_cout",  cout8, 1'b1);
            check("hold_valid", ov8,   1'b0);
        end

        run8("pre_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_sum",   sum8,  0);
        check("async_rst_cout",  cout8, 0);
        check("async_rst_valid", ov8,   0);
        a8 = 8'hF0; b8 = 8'h1F; cin8 = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_sum",   sum8,  0);
            check("rst_hold_cout",  cout8, 0);
            check("rst_hold_valid", ov8,   0);
        end
        #3 rst_n = 1'b1;
        run8("post_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        v16 = 1'b1; v32 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            a32 = $urandom;      b32 = $urandom;      cin32 = 1'($urandom);
            if (n == 0) begin
                a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; cin32 = 1'b1;
            end
            e8  = 64'(a8)  + 64'(b8)  + 64'(cin8);
            e16 = 64'(a16) + 64'(b16) + 64'(cin16);
            e32 = 64'(a32) + 64'(b32) + 64'(cin32);
            tick();
            check("rand8",    {cout8, sum8},   e8);
            check("rand16",   {cout16, sum16}, e16);
            check("rand32",   {cout32, sum32}, e32);
            check("rand_vld", {ov8, ov16, ov32}, 3'b111);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
